// File: rtl/mac_acc_pipe.sv
// N-lane signed/unsigned dot product with a registered adder tree and a grouped
// accumulator delimited by first/last tags; optional saturation at ACCW.
module mac_acc_pipe #(
  parameter  int WI   = 8,
  parameter  int N    = 16,
  localparam int WN   = $clog2(N),
  localparam int PW   = 2*WI+1,
  localparam int TW   = PW+WN,
  parameter  int ACCW = TW+8,
  parameter  bit SAT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic                   sgn_i,
  input  logic [N*WI-1:0]        win,
  input  logic [N*WI-1:0]        din,
  output logic signed [ACCW-1:0] acc_o,
  output logic                   vld_o,
  output logic                   ovf_o
);

  logic [N*WI-1:0] w_reg, x_reg;
  logic            sgn_reg;
  logic [WN:0]     vld_sr, first_sr, last_sr;

  // Index k of the tag shift registers lines up with tree level k.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg    <= '0;
      x_reg    <= '0;
      sgn_reg  <= 1'b0;
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else begin
      w_reg    <= win;
      x_reg    <= din;
      sgn_reg  <= sgn_i;
      vld_sr   <= {vld_sr[WN-1:0], vld_i};
      first_sr <= {first_sr[WN-1:0], first_i};
      last_sr  <= {last_sr[WN-1:0], last_i};
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi <= WN; gi++) begin : g_lvl
      localparam int LW = PW + gi;
      localparam int LN = N >> gi;
      logic signed [LW-1:0] node [LN];

      if (gi == 0) begin : g_leaf
        // Operands widened to PW bits: the true product always fits, so the
        // modulo-2^PW multiply is exact in both modes.
        for (gj = 0; gj < N; gj++) begin : g_mul
          logic signed [PW-1:0] w_ext, x_ext;
          assign w_ext = {{(PW-WI){sgn_reg & w_reg[gj*WI+WI-1]}}, w_reg[gj*WI +: WI]};
          assign x_ext = {{(PW-WI){sgn_reg & x_reg[gj*WI+WI-1]}}, x_reg[gj*WI +: WI]};
          assign node[gj] = w_ext * x_ext;
        end
      end else begin : g_add
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int j = 0; j < LN; j++) node[j] <= '0;
          end else begin
            for (int j = 0; j < LN; j++)
              node[j] <= {g_lvl[gi-1].node[2*j][LW-2],   g_lvl[gi-1].node[2*j]} +
                         {g_lvl[gi-1].node[2*j+1][LW-2], g_lvl[gi-1].node[2*j+1]};
          end
        end
      end
    end
  endgenerate

  logic signed [TW-1:0]   root;
  logic signed [ACCW-1:0] acc_reg, base_acc, acc_nx, fin_acc_reg;
  logic [ACCW:0]          sum_ext;
  logic                   ovf_reg, base_ovf, ovf_nx, restart;
  logic                   open_reg, fin_vld_reg, fin_ovf_reg;

  assign root = g_lvl[WN].node[0];

  // A beat with no group open starts one even without first.
  always_comb begin
    restart  = first_sr[WN] | ~open_reg;
    base_acc = restart ? '0 : acc_reg;
    base_ovf = restart ? 1'b0 : ovf_reg;
    sum_ext  = {base_acc[ACCW-1], base_acc} + {{(ACCW+1-TW){root[TW-1]}}, root};
    acc_nx   = sum_ext[ACCW-1:0];
    ovf_nx   = base_ovf;
    if (SAT && base_ovf) begin
      acc_nx = base_acc;
    end else if (sum_ext[ACCW] != sum_ext[ACCW-1]) begin
      ovf_nx = 1'b1;
      if (SAT)
        acc_nx = sum_ext[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      ovf_reg     <= 1'b0;
      open_reg    <= 1'b0;
      fin_vld_reg <= 1'b0;
      fin_acc_reg <= '0;
      fin_ovf_reg <= 1'b0;
      acc_o       <= '0;
      vld_o       <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      fin_vld_reg <= vld_sr[WN] & last_sr[WN];
      if (vld_sr[WN]) begin
        if (last_sr[WN]) begin
          fin_acc_reg <= acc_nx;
          fin_ovf_reg <= ovf_nx;
          acc_reg     <= '0;
          ovf_reg     <= 1'b0;
          open_reg    <= 1'b0;
        end else begin
          acc_reg  <= acc_nx;
          ovf_reg  <= ovf_nx;
          open_reg <= 1'b1;
        end
      end
      vld_o <= fin_vld_reg;
      if (fin_vld_reg) begin
        acc_o <= fin_acc_reg;
        ovf_o <= fin_ovf_reg;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: saturating and wrapping instances share stimulus and are
// checked every cycle against a group-level model plus literal per-pulse results.
module tb_mac_acc_pipe;
  localparam int WI   = 8;
  localparam int N    = 16;
  localparam int WN   = $clog2(N);
  localparam int ACCW = 22;
  localparam longint AMAX = (longint'(1) << (ACCW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACCW-1));
  localparam longint AMOD = longint'(1) << ACCW;

  logic clk, rst, vld_i, first_i, last_i, sgn_i;
  logic [N*WI-1:0] win, din;
  logic signed [ACCW-1:0] acc_s, acc_w;
  logic vld_s, vld_w, ovf_s, ovf_w;

  mac_acc_pipe #(.WI(WI), .N(N), .ACCW(ACCW), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .sgn_i(sgn_i), .win(win), .din(din), .acc_o(acc_s), .vld_o(vld_s), .ovf_o(ovf_s));

  mac_acc_pipe #(.WI(WI), .N(N), .ACCW(ACCW), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .sgn_i(sgn_i), .win(win), .din(din), .acc_o(acc_w), .vld_o(vld_w), .ovf_o(ovf_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int due; longint s; longint w; bit os; bit ow;} ev_t;
  typedef struct {longint s; longint w; bit os; bit ow;} lit_t;
  ev_t  evq[$];
  lit_t litq[$];

  int     n_checks = 0, n_fail = 0, edge_n = 0;
  bit     exp_vld = 0, exp_os = 0, exp_ow = 0;
  longint exp_s = 0, exp_w = 0;
  bit     grp_open = 0, mo_s = 0, mo_w = 0;
  longint m_s = 0, m_w = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic longint beat_sum(input logic [N*WI-1:0] w, input logic [N*WI-1:0] x,
                                      input logic s);
    longint t = 0;
    for (int k = 0; k < N; k++) begin
      logic [WI-1:0] wb, xb;
      longint a, b;
      wb = w[k*WI +: WI];
      xb = x[k*WI +: WI];
      a = s ? longint'($signed(wb)) : longint'(wb);
      b = s ? longint'($signed(xb)) : longint'(xb);
      t += a * b;
    end
    return t;
  endfunction

  task automatic step(input longint a, input bit o, input longint sum, input bit sat,
                      output longint a_out, output bit o_out);
    longint n;
    n = a + sum;
    o_out = o;
    if (sat && o) a_out = a;
    else if (n > AMAX) begin o_out = 1; a_out = sat ? AMAX : n - AMOD; end
    else if (n < AMIN) begin o_out = 1; a_out = sat ? AMIN : n + AMOD; end
    else a_out = n;
  endtask

  // Group-level model: expected outputs for the edge just taken.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      evq.delete();
      grp_open = 0; m_s = 0; m_w = 0; mo_s = 0; mo_w = 0;
      exp_vld = 0; exp_s = 0; exp_w = 0; exp_os = 0; exp_ow = 0;
    end else begin
      exp_vld = 0;
      if (evq.size() > 0 && evq[0].due == edge_n) begin
        ev_t e;
        e = evq.pop_front();
        exp_vld = 1; exp_s = e.s; exp_w = e.w; exp_os = e.os; exp_ow = e.ow;
      end
      if (vld_i) begin
        longint sum;
        sum = beat_sum(win, din, sgn_i);
        if (first_i || !grp_open) begin m_s = 0; m_w = 0; mo_s = 0; mo_w = 0; end
        step(m_s, mo_s, sum, 1'b1, m_s, mo_s);
        step(m_w, mo_w, sum, 1'b0, m_w, mo_w);
        if (last_i) begin
          evq.push_back('{edge_n + WN + 2, m_s, m_w, mo_s, mo_w});
          grp_open = 0; m_s = 0; m_w = 0; mo_s = 0; mo_w = 0;
        end else grp_open = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (edge_n > 0) begin
      check("vld_sat", longint'(vld_s), longint'(exp_vld));
      check("vld_wrap", longint'(vld_w), longint'(exp_vld));
      check("acc_sat", longint'(acc_s), exp_s);
      check("acc_wrap", longint'(acc_w), exp_w);
      check("ovf_sat", longint'(ovf_s), longint'(exp_os));
      check("ovf_wrap", longint'(ovf_w), longint'(exp_ow));
      if (exp_vld) begin
        if (litq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL lit_extra_pulse: got pulse expected none (edge %0d)", edge_n);
        end else begin
          lit_t l;
          l = litq.pop_front();
          check("lit_acc_sat", longint'(acc_s), l.s);
          check("lit_acc_wrap", longint'(acc_w), l.w);
          check("lit_ovf_sat", longint'(ovf_s), longint'(l.os));
          check("lit_ovf_wrap", longint'(ovf_w), longint'(l.ow));
        end
      end
    end
  end

  function automatic logic [N*WI-1:0] fill(input logic [WI-1:0] v);
    return {N{v}};
  endfunction

  function automatic logic [N*WI-1:0] lane0(input logic [WI-1:0] v);
    logic [N*WI-1:0] r;
    r = '0;
    r[WI-1:0] = v;
    return r;
  endfunction

  task automatic beat(input logic s, input logic f, input logic l,
                      input logic [N*WI-1:0] w, input logic [N*WI-1:0] x);
    @(negedge clk);
    vld_i = 1; sgn_i = s; first_i = f; last_i = l; win = w; din = x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld_i = 0; first_i = 0; last_i = 0;
    end
  endtask

  initial begin
    rst = 1; vld_i = 0; first_i = 0; last_i = 0; sgn_i = 0; win = '0; din = '0;
    litq.push_back('{16, 16, 0, 0});
    litq.push_back('{262144, 262144, 0, 0});
    litq.push_back('{1040400, 1040400, 0, 0});
    litq.push_back('{400, 400, 0, 0});
    litq.push_back('{400, 400, 0, 0});
    litq.push_back('{2097151, -1073104, 1, 1});
    litq.push_back('{16, 16, 0, 0});
    litq.push_back('{-2097152, 1853456, 1, 1});
    litq.push_back('{16, 16, 0, 0});
    litq.push_back('{50, 50, 0, 0});
    litq.push_back('{200, 200, 0, 0});
    idle(3);
    rst = 0;
    // single-beat group of ones
    beat(1, 1, 1, fill(8'd1), fill(8'd1));
    idle(8);
    // signed extreme then unsigned extreme, back to back
    beat(1, 1, 1, fill(8'h80), fill(8'h80));
    beat(0, 1, 1, fill(8'hff), fill(8'hff));
    idle(8);
    // four-beat groups: contiguous, then with bubbles
    for (int i = 0; i < 4; i++) beat(1, i == 0, i == 3, lane0(8'd10), lane0(8'd10));
    idle(3);
    for (int i = 0; i < 4; i++) begin
      beat(1, i == 0, i == 3, lane0(8'd10), lane0(8'd10));
      if (i < 3) idle(2);
    end
    idle(8);
    // positive overflow, then a clean group immediately after
    for (int i = 0; i < 3; i++) beat(0, i == 0, i == 2, fill(8'hff), fill(8'hff));
    beat(1, 1, 1, fill(8'd1), fill(8'd1));
    idle(8);
    // negative overflow, then a positive beat that must not unclamp
    for (int i = 0; i < 9; i++) beat(1, i == 0, 1'b0, fill(8'h80), fill(8'h7f));
    beat(1, 0, 1, fill(8'd1), fill(8'd1));
    idle(8);
    // reset with beats in flight
    beat(1, 1, 0, lane0(8'd10), lane0(8'd10));
    beat(1, 0, 0, lane0(8'd10), lane0(8'd10));
    @(negedge clk);
    vld_i = 0; first_i = 0; last_i = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    idle(8);
    beat(1, 1, 1, fill(8'd1), fill(8'd1));
    idle(8);
    // first reasserted mid-group
    beat(1, 1, 0, lane0(8'd10), lane0(8'd30));
    beat(1, 1, 1, lane0(8'd5), lane0(8'd10));
    idle(8);
    // beat without first and no open group starts a group
    beat(1, 0, 0, lane0(8'd10), lane0(8'd10));
    beat(1, 0, 1, lane0(8'd10), lane0(8'd10));
    idle(10);
    check("pulses_missing", longint'(litq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
